// File: rtl/gnr_ctrl_pkg.sv
// rtl/gnr_ctrl_pkg.sv - shared types and defaults for the attractor sequencer
package gnr_ctrl_pkg;

  localparam int N_NODES_DEF = 16;
  localparam int CNT_W_DEF   = 16;
  // Idle cycles between consecutive node strobes; the tortoise steps every STROBE_GAP+1 hare pulses.
  localparam int STROBE_GAP  = 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STEP,
    CHECK,
    PSTEP,
    PCHECK,
    DONE
  } state_e;

endpackage

// File: rtl/gnr_attractor_ctrl.sv
// rtl/gnr_attractor_ctrl.sv - Floyd attractor search and period measurement for a boolean node array
module gnr_attractor_ctrl
  import gnr_ctrl_pkg::*;
#(
  parameter int N_NODES = N_NODES_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_NODES-1:0] init_vec,
  input  logic [CNT_W-1:0]   max_steps,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic               timeout,
  output logic [CNT_W-1:0]   step_cnt,
  output logic [CNT_W-1:0]   period,
  output logic [N_NODES-1:0] attr_state
);

  localparam logic [CNT_W-1:0] TORTOISE_DIV = CNT_W'(STROBE_GAP + 1);

  state_e state;
  logic   tortoise_aligned;

  // s0 only equals x_k against s1 = x_2k once an even number of hare pulses has gone out.
  assign tortoise_aligned = ((step_cnt % TORTOISE_DIV) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      reset_nos  <= 1'b0;
      init_state <= '0;
      start_s0   <= 1'b0;
      start_s1   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      timeout    <= 1'b0;
      step_cnt   <= '0;
      period     <= '0;
      attr_state <= '0;
    end else begin
      reset_nos  <= 1'b0;
      init_state <= '0;
      start_s0   <= 1'b0;
      start_s1   <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            reset_nos  <= 1'b1;
            init_state <= init_vec;
            busy       <= 1'b1;
            done       <= 1'b0;
            found      <= 1'b0;
            timeout    <= 1'b0;
            step_cnt   <= '0;
            period     <= '0;
            attr_state <= '0;
          end
        end
        LOAD: begin
          state    <= STEP;
          start_s0 <= 1'b1;
          start_s1 <= 1'b1;
        end
        STEP: begin
          state    <= CHECK;
          step_cnt <= (step_cnt == '1) ? step_cnt : step_cnt + 1'b1;
        end
        CHECK: begin
          if (tortoise_aligned && (s0_vec == s1_vec)) begin
            state      <= PSTEP;
            attr_state <= s0_vec;
            found      <= 1'b1;
            start_s1   <= 1'b1;
          end else if (step_cnt == max_steps) begin
            state   <= DONE;
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state    <= STEP;
            start_s0 <= 1'b1;
            start_s1 <= 1'b1;
          end
        end
        PSTEP: begin
          state  <= PCHECK;
          period <= (period == '1) ? period : period + 1'b1;
        end
        PCHECK: begin
          if (s1_vec == attr_state) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (period == max_steps) begin
            // Budget ran out inside the cycle; found stays set, period is not meaningful.
            state   <= DONE;
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state    <= PSTEP;
            start_s1 <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// tb/tb_gnr_attractor_ctrl.sv - randomized and directed bench for gnr_attractor_ctrl
module tb_gnr_attractor_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] init_vec = '0;
  logic [15:0] max_steps = 16'd1;
  logic [15:0] s0_vec = '0;
  logic [15:0] s1_vec = '0;
  logic        reset_nos, start_s0, start_s1, busy, done, found, timeout;
  logic [15:0] init_state, step_cnt, period, attr_state;

  int          checks = 0;
  int          errors = 0;
  int          mode = 0;
  logic [3:0]  tbl [16];
  logic        pass = 1'b0;

  gnr_attractor_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init_vec(init_vec), .max_steps(max_steps),
    .s0_vec(s0_vec), .s1_vec(s1_vec), .reset_nos(reset_nos), .init_state(init_state),
    .start_s0(start_s0), .start_s1(start_s1), .busy(busy), .done(done), .found(found),
    .timeout(timeout), .step_cnt(step_cnt), .period(period), .attr_state(attr_state)
  );

  always #5 clk = ~clk;

  // Network transfer function selected by mode.
  function automatic logic [15:0] f(logic [15:0] s);
    case (mode)
      0:       return s;
      1:       return (s + 16'd1) % 16'd6;
      2:       return (s < 16'd4) ? s + 16'd1 : 16'd2;
      default: return {12'd0, tbl[s[3:0]]};
    endcase
  endfunction

  // Node array: hare on every start_s1, tortoise on every other start_s0.
  always @(posedge clk) begin
    if (reset_nos) begin
      s0_vec <= init_state;
      s1_vec <= init_state;
      pass   <= 1'b1;
    end else begin
      if (start_s1) s1_vec <= f(s1_vec);
      if (start_s0) begin
        if (pass) s0_vec <= f(s0_vec);
        pass <= ~pass;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_nos || start_s0 || start_s1) begin
      checks++;
      assert (!(reset_nos && (start_s0 || start_s1)) && !(start_s0 && found) && !done)
      else begin
        errors++;
        $error("FAIL proto rn=%0b s0=%0b s1=%0b found=%0b done=%0b", reset_nos, start_s0, start_s1, found, done);
      end
    end
  end

  task automatic chk(string tag, string what, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // Reference: tortoise/hare on the explicit trajectory x_0, x_1, ...
  task automatic model(input logic [15:0] iv, input int mx, output int sc, output int per,
                       output bit fnd, output bit to, output logic [15:0] attr, output int cyc);
    logic [15:0] xs[$];
    int k;
    xs.push_back(iv);
    for (int i = 1; i <= 3 * mx + 2; i++) xs.push_back(f(xs[i-1]));
    fnd = 0; to = 0; sc = mx; per = 0; attr = '0; k = 0;
    for (int j = 1; 2 * j <= mx; j++) begin
      if (xs[j] == xs[2*j]) begin
        fnd = 1; k = j; sc = 2 * j; attr = xs[j];
        break;
      end
    end
    if (!fnd) to = 1;
    else begin
      per = mx; to = 1;
      for (int p = 1; p <= mx; p++) begin
        if (xs[2*k+p] == xs[k]) begin
          per = p; to = 0;
          break;
        end
      end
    end
    cyc = 2 + 2 * sc + 2 * per;
  endtask

  task automatic run(int m, logic [15:0] iv, logic [15:0] mx, bit poke, string tag);
    int sc, per, cyc, exp_cyc;
    bit fnd, to, got;
    logic [15:0] attr;
    mode = m;
    init_vec = iv;
    max_steps = mx;
    model(iv, int'(mx), sc, per, fnd, to, attr, exp_cyc);
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    got = 0;
    while (cyc < 2000 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (poke && cyc == 2) start = 1'b1;
      if (poke && cyc == 3) start = 1'b0;
      if (done) got = 1;
    end
    chk(tag, "done", 32'(got), 32'd1);
    chk(tag, "latency", 32'(cyc), 32'(exp_cyc));
    chk(tag, "found", 32'(found), 32'(fnd));
    chk(tag, "timeout", 32'(timeout), 32'(to));
    chk(tag, "step_cnt", 32'(step_cnt), 32'(sc));
    chk(tag, "busy", 32'(busy), 32'd0);
    if (fnd) begin
      chk(tag, "attr_state", 32'(attr_state), 32'(attr));
      chk(tag, "period", 32'(period), 32'(per));
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) tbl[i] = 4'(i);
    repeat (3) @(negedge clk);
    chk("reset", "flags", 32'({reset_nos, start_s0, start_s1, busy, done, found, timeout}), 32'd0);
    chk("reset", "counts", {step_cnt, period}, 32'd0);
    chk("reset", "vecs", {attr_state, init_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 16'h00A5, 16'd100, 0, "ident");
    run(1, 16'd0, 16'd100, 0, "mod6");
    run(1, 16'd0, 16'd8, 0, "mod6_to");
    run(2, 16'd0, 16'd100, 0, "tail");
    run(2, 16'd0, 16'd100, 1, "poke");
    run(1, 16'd3, 16'd7, 0, "odd_max");

    // Drop reset in the middle of the period phase.
    mode = 1; init_vec = 16'd0; max_steps = 16'd100;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (n < 200 && !(found && start_s1)) begin
      @(negedge clk);
      n++;
    end
    chk("rst", "reached_pstep", 32'(found && start_s1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst", "flags", 32'({reset_nos, start_s0, start_s1, busy, done, found, timeout}), 32'd0);
    chk("rst", "counts", {step_cnt, period}, 32'd0);
    chk("rst", "vecs", {attr_state, init_state}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst", "quiet", 32'({reset_nos, start_s0, start_s1, busy}), 32'd0);
    end
    rst_n = 1'b1;
    run(1, 16'd0, 16'd100, 0, "rerun");

    for (int r = 0; r < 15; r++) begin
      int m;
      logic [15:0] iv;
      m = int'($urandom_range(0, 3));
      for (int i = 0; i < 16; i++) tbl[i] = 4'($urandom_range(0, 15));
      case (m)
        0:       iv = 16'($urandom);
        1:       iv = 16'($urandom_range(0, 5));
        2:       iv = 16'($urandom_range(0, 4));
        default: iv = 16'($urandom_range(0, 15));
      endcase
      run(m, iv, 16'($urandom_range(1, 40)), 0, $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
